// File: rtl/data_count_pkg.sv
// Shared types and constants for the data_count_ctrl frame sequencer.
package data_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CNT_W         = 4;
    localparam int unsigned FRAME_LEN_DEF = 8;
    localparam int unsigned CHK0          = FRAME_LEN_DEF - 1;
    localparam int unsigned CHK1          = FRAME_LEN_DEF;

    function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/frame_acc.sv
// Frame accumulator: running sum of data words plus the last accepted word,
// with the combinational a/d paths feeding the downstream check register.
module frame_acc
    import data_count_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          add_en,
    input  logic          cap_en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] acc,
    output logic [DW-1:0] a,
    output logic [DW-1:0] d
);

    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_last;
    logic [DW-1:0] w_sum;

    assign w_sum = r_acc + din;

    // Synchronous clear outranks both enables so an aborted word is never summed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_last <= '0;
        end else if (clr) begin
            r_acc  <= '0;
            r_last <= '0;
        end else begin
            if (add_en) r_acc  <= w_sum;
            if (cap_en) r_last <= din;
        end
    end

    assign acc = r_acc;
    assign d   = add_en ? w_sum : r_acc;
    assign a   = cap_en ? din : r_last;

endmodule

// File: rtl/data_count_ctrl.sv
// Frame sequencer: accepts FRAME_LEN words, drives the check register's
// count/sum/raw inputs and verifies the two trailing check words.
module data_count_ctrl
    import data_count_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [DW-1:0]    din,
    output logic             ready,
    output logic [CNT_W-1:0] data_count,
    output logic [CNT_W-1:0] next_data_count,
    output logic [DW-1:0]    a,
    output logic [DW-1:0]    d,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] L_CHK0 = to_cnt(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] L_CHK1 = to_cnt(FRAME_LEN);

    state_t           r_state;
    logic [CNT_W-1:0] r_data_count;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic [CNT_W-1:0] w_next;
    logic             w_data_word;
    logic             w_chk0;
    logic             w_chk1;
    logic             w_bad;
    logic             w_acc_clr;
    logic [DW-1:0]    w_acc;

    assign ready    = (r_state == LOAD);
    assign busy     = (r_state != IDLE);
    assign w_accept = wr_en & ready;

    always_comb begin
        w_next = '0;
        if (r_state == LOAD)
            w_next = r_data_count + {{(CNT_W-1){1'b0}}, w_accept};
    end

    // w_next only moves past data_count on an accept, so these imply accept.
    assign w_data_word = w_accept && (w_next < L_CHK0);
    assign w_chk0      = w_accept && (w_next == L_CHK0);
    assign w_chk1      = w_accept && (w_next == L_CHK1);
    assign w_bad       = (w_chk0 && (din != w_acc)) || (w_chk1 && (din != ~w_acc));
    assign w_acc_clr   = clear || ((r_state == IDLE) && start);

    frame_acc #(
        .DW(DW)
    ) u_frame_acc (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (w_acc_clr),
        .add_en (w_data_word),
        .cap_en (w_accept),
        .din    (din),
        .acc    (w_acc),
        .a      (a),
        .d      (d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_data_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else if (clear) begin
            r_state      <= IDLE;
            r_data_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state      <= LOAD;
                        r_data_count <= '0;
                        r_err        <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_data_count <= w_next;
                        if (w_bad) r_err <= 1'b1;
                        if (w_next == L_CHK1) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_done       <= 1'b0;
                    r_data_count <= '0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_done       <= 1'b0;
                    r_data_count <= '0;
                end
            endcase
        end
    end

    assign data_count      = r_data_count;
    assign next_data_count = w_next;
    assign done            = r_done;
    assign err             = r_err;

endmodule
